// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit CLA group is resolved per stage,
// with per-stage valid bits and a global stall driven by the output handshake.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned GROUP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num_one,
  input  logic [WIDTH-1:0] num_two,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned STAGES = WIDTH / GROUP;

  if (WIDTH % GROUP != 0) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
  end

  // Lookahead carries c[0..GROUP] of one group from group generate/propagate prefixes.
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] a,
                                                 input logic [GROUP-1:0] b,
                                                 input logic             c0);
    logic [GROUP:0] c;
    logic           gen;
    logic           prop;
    gen  = 1'b0;
    prop = 1'b1;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      gen      = (a[i] & b[i]) | ((a[i] ^ b[i]) & gen);
      prop     = prop & (a[i] ^ b[i]);
      c[i + 1] = gen | (prop & c0);
    end
    return c;
  endfunction

  logic stall;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Rem: operand bits still unresolved on entry; Done: sum bits resolved on exit.
    localparam int unsigned Rem  = WIDTH - k * GROUP;
    localparam int unsigned Done = (k + 1) * GROUP;

    logic [Rem-1:0]   a_i;
    logic [Rem-1:0]   b_i;
    logic             c_i;
    logic             v_i;
    logic [GROUP:0]   c;
    logic [GROUP-1:0] grp_s;
    logic [Done-1:0]  s_d;
    logic [Done-1:0]  s_q;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_head
      assign a_i = num_one;
      assign b_i = num_two ^ {WIDTH{sub}};
      assign c_i = cin ^ sub;
      assign v_i = in_valid;
      assign s_d = grp_s;
    end else begin : g_link
      assign a_i = g_stage[k-1].g_ops.a_q;
      assign b_i = g_stage[k-1].g_ops.b_q;
      assign c_i = g_stage[k-1].c_q;
      assign v_i = g_stage[k-1].v_q;
      assign s_d = {grp_s, g_stage[k-1].s_q};
    end

    assign c     = cla_carries(a_i[GROUP-1:0], b_i[GROUP-1:0], c_i);
    assign grp_s = a_i[GROUP-1:0] ^ b_i[GROUP-1:0] ^ c[GROUP-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_i;
        c_q <= c[GROUP];
        s_q <= s_d;
      end
    end

    // Only the still-unresolved upper operand bits travel to the next stage.
    if (k < STAGES - 1) begin : g_ops
      logic [Rem-GROUP-1:0] a_q;
      logic [Rem-GROUP-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_i[Rem-1:GROUP];
          b_q <= b_i[Rem-1:GROUP];
        end
      end
    end else begin : g_tail
      logic ov_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_q <= 1'b0;
        end else if (!stall) begin
          ov_q <= c[GROUP] ^ c[GROUP-1];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign S         = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign overflow  = g_stage[STAGES-1].g_tail.ov_q;

endmodule
